// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity modes, frame bit positions and FSM encoding.
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Bit positions within one frame as it appears on the line
    localparam int START      = 0;
    localparam int DATA_FIRST = 1;
    localparam int DATA_LAST  = 8;
    localparam int PARITY     = 9;
    localparam int STOP       = 10;

    // Index of the final data bit, counted from zero
    localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_LAST - DATA_FIRST);

    // State encoding is shared with the receiver; keep the order stable
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } usrt_state_t;

endpackage

// File: rtl/usrt_tx_frame_txparity.sv
// Parity generator for the transmit path; same definition as the receiver's checker.
module txparity
    import usrt_pkg::*;
(
    input  logic [7:0] i_Data,
    input  logic [1:0] i_Parity,
    output logic       o_ParityBit,
    output logic       o_Enable
);

    // Even mode sends the XOR of the data bits, odd mode its inverse; 11 behaves as none
    always_comb begin
        o_Enable    = (i_Parity == PAR_EVEN) || (i_Parity == PAR_ODD);
        o_ParityBit = (^i_Data) ^ (i_Parity == PAR_ODD);
    end

endmodule

// File: rtl/usrt_tx_frame.sv
// USRT transmit framer: accepts a byte per handshake and shifts out
// start, 8 data bits LSB-first, optional parity and stop on o_Tx.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | line idle high, ready for a byte
// ST_START  | start bit (0)
// ST_DATA   | data bits, LSB first, bit_idx selects 0..7
// ST_PARITY | parity bit, only when the latched mode enables it
// ST_STOP   | stop bit (1); last clock can accept the next byte
module usrt_tx_frame
    import usrt_pkg::*;
#(
    parameter int g_CLKS_PER_BIT = 1
) (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    input  logic [1:0] i_Parity,
    input  logic [7:0] i_Data,
    input  logic       i_Valid,
    output logic       o_Ready,
    output logic       o_Tx,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int CW = $clog2(g_CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(g_CLKS_PER_BIT - 1);

    usrt_state_t   state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [2:0]    idx_q, idx_nxt;
    logic [7:0]    shreg_q, shreg_nxt;
    logic          par_bit_q, par_bit_nxt;
    logic          par_en_q, par_en_nxt;
    logic          tx_q, tx_nxt;

    logic          par_bit_w;
    logic          par_en_w;
    logic          bit_end;
    logic          last_stop;
    logic          accept;

    txparity u_txparity (
        .i_Data      (i_Data),
        .i_Parity    (i_Parity),
        .o_ParityBit (par_bit_w),
        .o_Enable    (par_en_w)
    );

    // Handshake and status decode from registered state
    always_comb begin
        bit_end   = (cnt_q == '0);
        last_stop = (state_q == ST_STOP) && bit_end;
        o_Ready   = (state_q == ST_IDLE) || last_stop;
        o_Done    = last_stop;
        o_Busy    = (state_q != ST_IDLE);
        o_Tx      = tx_q;
        accept    = i_Valid && o_Ready;
    end

    // Next-state, bit timer, shifter and next line value
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        idx_nxt     = idx_q;
        shreg_nxt   = shreg_q;
        par_bit_nxt = par_bit_q;
        par_en_nxt  = par_en_q;

        if (!bit_end) begin
            cnt_nxt = cnt_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_nxt = '0;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = CNT_LOAD;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_nxt = CNT_LOAD;
                    if (idx_q == LAST_DATA_IDX) begin
                        state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_nxt   = idx_q + 3'd1;
                        shreg_nxt = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A new byte overrides the IDLE / end-of-STOP transition, giving gapless frames
        if (accept) begin
            state_nxt   = ST_START;
            cnt_nxt     = CNT_LOAD;
            idx_nxt     = '0;
            shreg_nxt   = i_Data;
            par_bit_nxt = par_bit_w;
            par_en_nxt  = par_en_w;
        end

        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg_nxt[0];
            ST_PARITY: tx_nxt = par_bit_nxt;
            default:   tx_nxt = 1'b1;
        endcase
    end

    // State and datapath registers; o_Tx comes straight from a flop
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            idx_q     <= idx_nxt;
            shreg_q   <= shreg_nxt;
            par_bit_q <= par_bit_nxt;
            par_en_q  <= par_en_nxt;
            tx_q      <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_usrt_tx_frame.sv
// Self-checking bench for usrt_tx_frame: two instances (1 and 4 clocks per bit),
// directed frames followed by randomized frame bursts against a frame-level model.
module tb_usrt_tx_frame;

    typedef bit bitq_t[$];

    localparam int CPB0 = 1;
    localparam int CPB1 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic [1:0] p0, p1;
    logic       r0, r1, t0, t1, b0, b1, dn0, dn1;

    int npass  = 0;
    int ntotal = 0;
    int nfail  = 0;

    logic [7:0] fr_d[$];
    logic [1:0] fr_p[$];

    always #5 clk = ~clk;

    usrt_tx_frame #(.g_CLKS_PER_BIT(CPB0)) dut0 (
        .i_Pclk(clk), .i_Reset(rst), .i_Parity(p0), .i_Data(d0), .i_Valid(v0),
        .o_Ready(r0), .o_Tx(t0), .o_Busy(b0), .o_Done(dn0)
    );

    usrt_tx_frame #(.g_CLKS_PER_BIT(CPB1)) dut1 (
        .i_Pclk(clk), .i_Reset(rst), .i_Parity(p1), .i_Data(d1), .i_Valid(v1),
        .o_Ready(r1), .o_Tx(t1), .o_Busy(b1), .o_Done(dn1)
    );

    function automatic int cpb(input int u);
        return (u == 0) ? CPB0 : CPB1;
    endfunction

    // Line image of one frame, one entry per bit, built from the framing rules
    function automatic bitq_t frame_bits(input logic [7:0] d, input logic [1:0] m);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (m == 2'b01) q.push_back((ones % 2) == 1);
        if (m == 2'b10) q.push_back((ones % 2) == 0);
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic drive(input int u, input logic v, input logic [7:0] d, input logic [1:0] p);
        if (u == 0) begin
            v0 = v; d0 = d; p0 = p;
        end else begin
            v1 = v; d1 = d; p1 = p;
        end
    endtask

    task automatic sample(input int u, output logic tx, output logic rdy,
                          output logic bsy, output logic dne);
        tx  = (u == 0) ? t0  : t1;
        rdy = (u == 0) ? r0  : r1;
        bsy = (u == 0) ? b0  : b1;
        dne = (u == 0) ? dn0 : dn1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        logic tx, rdy, bsy, dne;
        sample(u, tx, rdy, bsy, dne);
        chk({tag, "_tx"},    32'(tx),  32'd1);
        chk({tag, "_ready"}, 32'(rdy), 32'd1);
        chk({tag, "_busy"},  32'(bsy), 32'd0);
        chk({tag, "_done"},  32'(dne), 32'd0);
    endtask

    // Sends the queued frames on instance u with i_Valid held across frames.
    // Entered and left just after a rising edge with the instance idle.
    task automatic stream(input int u, input string tag);
        int    n = fr_d.size();
        int    c_per = cpb(u);
        bitq_t bits;
        logic  tx, rdy, bsy, dne;
        bit    last;
        int    clk_idx, len_seen;
        drive(u, 1'b1, fr_d[0], fr_p[0]);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bits = frame_bits(fr_d[k], fr_p[k]);
            // Next byte (or random junk on idle inputs) must not disturb the frame in flight
            if (k + 1 < n) drive(u, 1'b1, fr_d[k+1], fr_p[k+1]);
            else           drive(u, 1'b0, 8'($urandom), 2'($urandom));
            clk_idx  = 0;
            len_seen = 0;
            for (int b = 0; b < bits.size(); b++) begin
                for (int c = 0; c < c_per; c++) begin
                    @(negedge clk);
                    sample(u, tx, rdy, bsy, dne);
                    last = (b == bits.size() - 1) && (c == c_per - 1);
                    clk_idx++;
                    if (dne === 1'b1 && len_seen == 0) len_seen = clk_idx;
                    chk($sformatf("%s_f%0d_b%0d_tx", tag, k, b), 32'(tx), 32'(bits[b]));
                    chk($sformatf("%s_f%0d_b%0d_busy", tag, k, b), 32'(bsy), 32'd1);
                    chk($sformatf("%s_f%0d_b%0d_ready", tag, k, b), 32'(rdy), 32'(last));
                    chk($sformatf("%s_f%0d_b%0d_done", tag, k, b), 32'(dne), 32'(last));
                    @(posedge clk); #1;
                end
            end
            chk($sformatf("%s_f%0d_len", tag, k), 32'(len_seen),
                32'(((fr_p[k] == 2'b01 || fr_p[k] == 2'b10) ? 11 : 10) * c_per));
        end
        @(negedge clk);
        chk_idle(u, {tag, "_after"});
        @(posedge clk); #1;
        fr_d.delete();
        fr_p.delete();
    endtask

    task automatic one(input int u, input logic [7:0] d, input logic [1:0] p, input string tag);
        fr_d.push_back(d);
        fr_p.push_back(p);
        stream(u, tag);
    endtask

    task automatic mid_reset(input int u, input string tag);
        drive(u, 1'b1, 8'($urandom), 2'b01);
        @(posedge clk); #1;
        drive(u, 1'b0, 8'h00, 2'b00);
        // START plus data bits 0..2, then one clock into data bit 3
        repeat (cpb(u) * 4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle(u, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 2'b00);
        drive(1, 1'b0, 8'h00, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");
        rst = 1'b0;
        @(posedge clk); #1;

        one(0, 8'h07, 2'b01, "even07");
        one(0, 8'h0F, 2'b10, "odd0F");
        one(0, 8'h07, 2'b10, "odd07");
        one(0, 8'hA5, 2'b00, "noneA5");
        one(0, 8'h3C, 2'b11, "rsvd3C");

        fr_d = '{8'h55, 8'hAA};
        fr_p = '{2'b01, 2'b01};
        stream(0, "b2b_c1");
        fr_d = '{8'h55, 8'hAA};
        fr_p = '{2'b01, 2'b10};
        stream(1, "b2b_c4");
        one(1, 8'h07, 2'b01, "even07_c4");

        mid_reset(0, "midrst_c1");
        mid_reset(1, "midrst_c4");

        // Reset and a valid request on the same edge: nothing may start
        rst = 1'b1;
        drive(0, 1'b1, 8'h81, 2'b01);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 2'b00);
        @(negedge clk);
        chk_idle(0, "rst_accept");
        @(posedge clk); #1;

        for (int it = 0; it < 30; it++) begin
            int u = int'($urandom_range(1, 0));
            int n = int'($urandom_range(3, 1));
            for (int k = 0; k < n; k++) begin
                fr_d.push_back(8'($urandom));
                fr_p.push_back(2'($urandom));
            end
            stream(u, $sformatf("rnd%0d", it));
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
